// File: rtl/ucsbece154b_icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states,
// default field widths and the address field extractor.
package ucsbece154b_icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2
  } state_t;

  // Field widths for the default geometry (32-bit address, 8 sets, 4-word lines).
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_NUM_SETS    = 8;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int OFF_W = $clog2(DEF_BLOCK_WORDS);
  localparam int IDX_W = $clog2(DEF_NUM_SETS);
  localparam int TAG_W = DEF_ADDR_WIDTH - IDX_W - OFF_W - 2;

  function automatic logic [63:0] extract_field(input logic [63:0] addr,
                                                input int         lsb,
                                                input int         width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// One way of the cache: per-set valid bit, tag and line data, with a
// combinational hit compare and a single word write port for refills.
module ucsbece154b_icache_way
  import ucsbece154b_icache_pkg::*;
#(
  parameter int NUM_SETS    = DEF_NUM_SETS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int TAG_BITS    = TAG_W,
  parameter int IDX_BITS    = IDX_W,
  parameter int OFF_BITS    = OFF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0] rd_tag,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic                hit,
  output logic                valid,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic [31:0]         wr_data,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                set_valid,
  input  logic                inv_all
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_mem  [NUM_SETS];
  logic [31:0]         data_mem [NUM_SETS][BLOCK_WORDS];

  assign valid   = valid_q[rd_idx];
  assign hit     = valid && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx][rd_off];

  // Invalidate-all clears first; a completing fill only sets its bit when no
  // invalidate is in flight, which the top already folds into set_valid.
  always_comb begin
    valid_d = valid_q;
    if (inv_all) valid_d = '0;
    if (set_valid) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[wr_idx][wr_off] <= wr_data;
    if (tag_we) tag_mem[wr_idx]          <= wr_tag;
  end

endmodule

// File: rtl/ucsbece154b_icache_sa.sv
// Set-associative instruction cache with critical-word-first burst refill,
// per-set round-robin replacement, invalidate-all and hit/miss counters.
module ucsbece154b_icache_sa
  import ucsbece154b_icache_pkg::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic [31:0]           Instruction,
  output logic                  Ready,
  output logic                  Busy,
  input  logic                  Invalidate,
  output logic [ADDR_WIDTH-1:0] MemReadAddress,
  output logic                  MemReadRequest,
  input  logic [31:0]           MemDataIn,
  input  logic                  MemDataReady,
  output logic [CNT_WIDTH-1:0]  HitCount,
  output logic [CNT_WIDTH-1:0]  MissCount
);

  localparam int OFF_BITS = $clog2(BLOCK_WORDS);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - OFF_BITS - 2;
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [TAG_BITS-1:0] addr_tag;
  logic [IDX_BITS-1:0] addr_idx;
  logic [OFF_BITS-1:0] addr_off;

  assign addr_off = OFF_BITS'(extract_field(64'(ReadAddress), 2, OFF_BITS));
  assign addr_idx = IDX_BITS'(extract_field(64'(ReadAddress), 2 + OFF_BITS, IDX_BITS));
  assign addr_tag = TAG_BITS'(extract_field(64'(ReadAddress), 2 + OFF_BITS + IDX_BITS, TAG_BITS));

  state_t               state_q, state_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [OFF_BITS-1:0]  off_q, off_d;
  logic [OFF_BITS-1:0]  beat_q, beat_d;
  logic [WAY_BITS-1:0]  victim_q, victim_d;
  logic                 inv_pend_q, inv_pend_d;
  logic [WAY_BITS-1:0]  rr_q [NUM_SETS];
  logic [WAY_BITS-1:0]  rr_d [NUM_SETS];
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [NUM_WAYS-1:0] way_hit, way_valid, way_sel;
  logic [31:0]         way_data [NUM_WAYS];
  logic                any_hit, fill_we, fill_done, set_valid;
  logic [31:0]         hit_data;
  logic [WAY_BITS-1:0] victim;
  logic [OFF_BITS-1:0] wr_word;

  assign wr_word   = off_q + beat_q;
  assign set_valid = fill_done && !inv_pend_q && !Invalidate;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign way_sel[w] = (victim_q == WAY_BITS'(w));
    ucsbece154b_icache_way #(
      .NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS),
      .TAG_BITS(TAG_BITS), .IDX_BITS(IDX_BITS), .OFF_BITS(OFF_BITS)
    ) u_way (
      .clk(Clk), .rst_n(Reset),
      .rd_idx(addr_idx), .rd_tag(addr_tag), .rd_off(addr_off),
      .hit(way_hit[w]), .valid(way_valid[w]), .rd_data(way_data[w]),
      .wr_en(fill_we && way_sel[w]), .wr_idx(idx_q), .wr_off(wr_word),
      .wr_data(MemDataIn), .tag_we(fill_done && way_sel[w]), .wr_tag(tag_q),
      .set_valid(set_valid && way_sel[w]), .inv_all(Invalidate)
    );
  end

  // Hit select, and victim choice: lowest invalid way, else the set's pointer.
  always_comb begin
    any_hit  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w]) begin
        any_hit  = 1'b1;
        hit_data = way_data[w];
      end
    end
    victim = rr_q[addr_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_BITS'(w);
    end
  end

  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    idx_d          = idx_q;
    off_d          = off_q;
    beat_d         = beat_q;
    victim_d       = victim_q;
    inv_pend_d     = inv_pend_q;
    rr_d           = rr_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    Ready          = 1'b0;
    Instruction    = '0;
    Busy           = 1'b0;
    MemReadRequest = 1'b0;
    MemReadAddress = '0;
    fill_we        = 1'b0;
    fill_done      = 1'b0;
    if (Reset) begin
      case (state_q)
        IDLE: begin
          inv_pend_d = 1'b0;
          if (ReadEnable && !Invalidate) begin
            if (any_hit) begin
              Ready       = 1'b1;
              Instruction = hit_data;
              hit_cnt_d   = hit_cnt_q + CNT_WIDTH'(1);
            end else begin
              Busy       = 1'b1;
              tag_d      = addr_tag;
              idx_d      = addr_idx;
              off_d      = addr_off;
              victim_d   = victim;
              miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
              state_d    = REQ;
            end
          end
        end
        REQ: begin
          Busy           = 1'b1;
          MemReadRequest = 1'b1;
          MemReadAddress = {tag_q, idx_q, off_q, 2'b00};
          beat_d         = '0;
          state_d        = REFILL;
          if (Invalidate) inv_pend_d = 1'b1;
        end
        REFILL: begin
          Busy = 1'b1;
          if (Invalidate) inv_pend_d = 1'b1;
          if (MemDataReady) begin
            fill_we = 1'b1;
            beat_d  = beat_q + OFF_BITS'(1);
            if (beat_q == '0 && ReadEnable &&
                {addr_tag, addr_idx, addr_off} == {tag_q, idx_q, off_q}) begin
              Ready       = 1'b1;
              Instruction = MemDataIn;
            end
            if (beat_q == OFF_BITS'(BLOCK_WORDS - 1)) begin
              fill_done   = 1'b1;
              rr_d[idx_q] = (rr_q[idx_q] == WAY_BITS'(NUM_WAYS - 1)) ?
                            '0 : rr_q[idx_q] + WAY_BITS'(1);
              inv_pend_d  = 1'b0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      beat_q     <= '0;
      victim_q   <= '0;
      inv_pend_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      beat_q     <= beat_d;
      victim_q   <= victim_d;
      inv_pend_q <= inv_pend_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rr_q       <= rr_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_ucsbece154b_icache_sa.sv
// Directed bench for the set-associative icache: cold refill, replacement,
// invalidate in IDLE and mid-refill, asynchronous reset and gapped bursts.
module tb_ucsbece154b_icache_sa;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ReadEnable = 1'b0;
  logic [31:0] ReadAddress = '0;
  logic [31:0] Instruction;
  logic        Ready, Busy;
  logic        Invalidate = 1'b0;
  logic [31:0] MemReadAddress;
  logic        MemReadRequest;
  logic [31:0] MemDataIn = '0;
  logic        MemDataReady = 1'b0;
  logic [31:0] HitCount, MissCount;

  int checks = 0;
  int failures = 0;

  ucsbece154b_icache_sa dut (
    .Clk(Clk), .Reset(Reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
    .Instruction(Instruction), .Ready(Ready), .Busy(Busy), .Invalidate(Invalidate),
    .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
    .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(posedge Clk); #1;
    Reset = 1'b0; ReadEnable = 1'b0; Invalidate = 1'b0; MemDataReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic hitFetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(posedge Clk); #1;
    ReadEnable = 1'b1; ReadAddress = addr;
    @(negedge Clk);
    checkOutput({tag, ".ready"}, 32'(Ready), 32'd1);
    checkOutput({tag, ".instr"}, Instruction, exp);
    @(posedge Clk); #1;
    ReadEnable = 1'b0;
  endtask

  // Miss on addr, then a critical-word-first burst of seed+0..seed+3 with
  // 'gap' idle cycles before each beat; Invalidate pulses with beat invBeat.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] seed,
                               input int gap, input int invBeat, input string tag);
    int readyCnt = 0;
    int reqCnt = 0;
    @(posedge Clk); #1;
    ReadEnable = 1'b1; ReadAddress = addr;
    @(negedge Clk);
    checkOutput({tag, ".missReady"}, 32'(Ready), 32'd0);
    checkOutput({tag, ".missBusy"}, 32'(Busy), 32'd1);
    @(posedge Clk); #1;
    @(negedge Clk);
    reqCnt += int'(MemReadRequest);
    checkOutput({tag, ".reqAddr"}, MemReadAddress, addr & 32'hFFFF_FFFC);
    @(posedge Clk); #1;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        MemDataReady = 1'b0;
        @(negedge Clk);
        checkOutput({tag, ".gapBusy"}, 32'(Busy), 32'd1);
        readyCnt += int'(Ready);
        reqCnt += int'(MemReadRequest);
        @(posedge Clk); #1;
      end
      MemDataReady = 1'b1;
      MemDataIn = seed + 32'(b);
      Invalidate = (b == invBeat);
      @(negedge Clk);
      if (b == 0) checkOutput({tag, ".critWord"}, Instruction, seed);
      readyCnt += int'(Ready);
      reqCnt += int'(MemReadRequest);
      @(posedge Clk); #1;
      Invalidate = 1'b0;
    end
    MemDataReady = 1'b0;
    ReadEnable = 1'b0;
    @(negedge Clk);
    checkOutput({tag, ".busyDone"}, 32'(Busy), 32'd0);
    checkOutput({tag, ".readyOnce"}, 32'(readyCnt), 32'd1);
    checkOutput({tag, ".reqOnce"}, 32'(reqCnt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state while Reset is held low.
    #12;
    checkOutput("rst.ready", 32'(Ready), 32'd0);
    checkOutput("rst.busy", 32'(Busy), 32'd0);
    checkOutput("rst.memReq", 32'(MemReadRequest), 32'd0);
    checkOutput("rst.instr", Instruction, 32'd0);
    checkOutput("rst.memAddr", MemReadAddress, 32'd0);
    checkOutput("rst.hits", HitCount, 32'd0);
    checkOutput("rst.misses", MissCount, 32'd0);
    applyReset();

    // 1: cold fetch of 0x08, beats A..D land in words 2,3,0,1.
    applyStimulus(32'h08, 32'hA, 0, -1, "t1");
    hitFetch(32'h0C, 32'hB, "t1.h0C");
    hitFetch(32'h00, 32'hC, "t1.h00");
    hitFetch(32'h04, 32'hD, "t1.h04");
    @(negedge Clk);
    checkOutput("t1.misses", MissCount, 32'd1);
    checkOutput("t1.hits", HitCount, 32'd3);

    // 2: five tags into set 0; the fifth evicts way 0 (line 0x000).
    applyReset();
    applyStimulus(32'h000, 32'h1000_0000, 0, -1, "t2a");
    applyStimulus(32'h080, 32'h1000_0080, 0, -1, "t2b");
    applyStimulus(32'h100, 32'h1000_0100, 0, -1, "t2c");
    applyStimulus(32'h180, 32'h1000_0180, 0, -1, "t2d");
    applyStimulus(32'h200, 32'h1000_0200, 0, -1, "t2e");
    hitFetch(32'h080, 32'h1000_0080, "t2.h080");
    applyStimulus(32'h000, 32'h2000_0000, 0, -1, "t2f");
    @(negedge Clk);
    checkOutput("t2.misses", MissCount, 32'd6);
    checkOutput("t2.hits", HitCount, 32'd1);

    // 3: invalidate in IDLE with a fetch present suppresses the hit.
    applyReset();
    applyStimulus(32'h40, 32'h4040_0000, 0, -1, "t3a");
    hitFetch(32'h44, 32'h4040_0001, "t3.h44");
    @(posedge Clk); #1;
    ReadEnable = 1'b1; ReadAddress = 32'h40; Invalidate = 1'b1;
    @(negedge Clk);
    checkOutput("t3.invReady", 32'(Ready), 32'd0);
    checkOutput("t3.invBusy", 32'(Busy), 32'd0);
    @(posedge Clk); #1;
    ReadEnable = 1'b0; Invalidate = 1'b0;
    @(negedge Clk);
    checkOutput("t3.hits", HitCount, 32'd1);
    checkOutput("t3.misses", MissCount, 32'd1);
    applyStimulus(32'h40, 32'h4040_0000, 0, -1, "t3b");

    // 4: invalidate on refill beat 1; the line completes but stays invalid.
    applyReset();
    applyStimulus(32'h40, 32'h5050_0000, 0, 1, "t4a");
    applyStimulus(32'h40, 32'h5050_0000, 0, -1, "t4b");
    @(negedge Clk);
    checkOutput("t4.misses", MissCount, 32'd2);

    // 5: asynchronous reset mid-refill, then stray beats while idle.
    applyReset();
    @(posedge Clk); #1;
    ReadEnable = 1'b1; ReadAddress = 32'h40;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    MemDataReady = 1'b1; MemDataIn = 32'h7777_0000;
    @(posedge Clk); #1;
    MemDataIn = 32'h7777_0001;
    #2 Reset = 1'b0;
    #1;
    checkOutput("t5.ready", 32'(Ready), 32'd0);
    checkOutput("t5.busy", 32'(Busy), 32'd0);
    checkOutput("t5.memReq", 32'(MemReadRequest), 32'd0);
    checkOutput("t5.hits", HitCount, 32'd0);
    checkOutput("t5.misses", MissCount, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1; ReadEnable = 1'b0;
    repeat (3) @(posedge Clk);
    #1 MemDataReady = 1'b0;
    @(negedge Clk);
    checkOutput("t5.strayBusy", 32'(Busy), 32'd0);
    applyStimulus(32'h40, 32'h7777_0000, 0, -1, "t5b");
    @(negedge Clk);
    checkOutput("t5.missesAfter", MissCount, 32'd1);

    // 6: two idle cycles before every beat; critical word 0x104 is word 1.
    applyReset();
    applyStimulus(32'h104, 32'h6600_0000, 2, -1, "t6");
    hitFetch(32'h100, 32'h6600_0003, "t6.h100");
    hitFetch(32'h10C, 32'h6600_0002, "t6.h10C");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_icache_sa.md
Name: ucsbece154b_icache_sa

Overview:
Parametrised set-associative instruction cache. It is the next-generation replacement for the direct-mapped instruction cache between the fetch stage and the emulated SDRAM, and drops into the same top-level socket. It adds configurable sets, ways and block size, critical-word-first wrapping burst refill, per-set round-robin replacement, invalidate-all, and hit/miss performance counters.

Parameters:
NUM_SETS, 8, number of sets; power of 2, at least 2.
NUM_WAYS, 4, associativity; power of 2, at least 1.
BLOCK_WORDS, 4, 32-bit words per line; power of 2, at least 2.
ADDR_WIDTH, 32, byte address width.
CNT_WIDTH, 32, width of each performance counter.

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
ReadEnable  in  1  fetch request valid.
ReadAddress  in  ADDR_WIDTH  byte address of the fetch; bits [1:0] are ignored.
Instruction  out  32  fetched word; valid when Ready=1.
Ready  out  1  Instruction valid this cycle.
Busy  out  1  miss or refill in progress.
Invalidate  in  1  synchronous invalidate-all pulse.
MemReadAddress  out  ADDR_WIDTH  word-aligned address of the critical word.
MemReadRequest  out  1  single-cycle burst request pulse.
MemDataIn  in  32  burst beat data.
MemDataReady  in  1  beat valid; exactly BLOCK_WORDS beats follow each request.
HitCount  out  CNT_WIDTH  number of hits.
MissCount  out  CNT_WIDTH  number of misses.

Behaviour:
- Address split: offset is [log2(BLOCK_WORDS)+1:2], index is the next log2(NUM_SETS) bits, tag is the remaining upper bits.
- Reset (asynchronous, Reset=0):
  - All valid bits, round-robin pointers, counters and the state register clear.
  - State goes to IDLE.
  - Ready, Busy and MemReadRequest are 0; Instruction and MemReadAddress are 0.
- Reset mid-refill aborts the refill. Any later MemDataReady beats for that request are ignored.
- State IDLE:
  - Lookup is combinational over the register arrays.
  - Hit (ReadEnable=1, a valid way with matching tag): Ready=1 and Instruction=data in the same cycle (zero-cycle latency); HitCount increments.
  - Miss: Ready=0, Busy=1 combinationally. Tag, index and offset are latched, MissCount increments, next state REQ.
  - Victim way: the lowest-numbered invalid way if one exists; otherwise the set's round-robin pointer.
- State REQ (one cycle):
  - MemReadRequest=1 and MemReadAddress={tag,index,offset,2'b00}.
  - Beat counter clears; next state REFILL.
- State REFILL:
  - Each MemDataReady beat is written to word (offset+beat) mod BLOCK_WORDS of the victim way; the counter increments.
  - Beat 0 is the critical word. On that beat, if ReadEnable=1 and ReadAddress matches the latched address, then Ready=1 and Instruction=MemDataIn.
  - After the critical beat is forwarded, hits to already-written words of the refilling line are not served. Ready stays 0 until IDLE.
  - On the final beat (counter = BLOCK_WORDS-1): tag is written, the valid bit is set unless an invalidate is pending, the set's round-robin pointer advances (mod NUM_WAYS), and next state is IDLE.
- Busy=1 in REQ and REFILL.
- No hit-under-miss. ReadAddress changes while Busy are tolerated; only the critical-word match gates Ready.
- Invalidate:
  - In IDLE, clears all valid bits on the next edge. Ready=0 that cycle and no counter update.
  - In REQ or REFILL, clears all valid bits and sets a pending flag. The refill completes but its line is not marked valid. The flag clears on return to IDLE.
- Counters wrap modulo 2^CNT_WIDTH. A miss counts once; critical-word forwarding is not a hit.
- Simultaneous Invalidate and miss in IDLE: the invalidate wins; no refill starts.
- MemDataReady in IDLE or REQ is ignored.

Decomposition:
- Shared package ucsbece154b_icache_pkg holds:
  - the state enum (IDLE, REQ, REFILL);
  - the derived widths OFF_W, IDX_W and TAG_W;
  - a field-extract function.
- One sub-module, ucsbece154b_icache_way: a single way's tag, valid and data arrays with hit compare and a beat-write port, instantiated NUM_WAYS times via generate.
- Replacement logic and the FSM stay in the top.

Test Plan:
1. Defaults, cold fetch of 0x0000_0008, memory beats 0xA,0xB,0xC,0xD one cycle apart:
   - MemReadRequest pulses once with address 0x08.
   - Ready and Instruction=0xA on beat 0.
   - Fetches of 0x0C, 0x00 and 0x04 then hit in the same cycle with 0xB, 0xC and 0xD.
   - MissCount=1, HitCount=3.
2. Fetch 0x000, 0x080, 0x100, 0x180, 0x200 (all set 0):
   - Five misses; the fifth replaces way 0.
   - Re-fetching 0x000 misses (MissCount=6); 0x080 still hits.
3. Pulse Invalidate in IDLE after filling a line at 0x40:
   - The next fetch of 0x40 misses and raises MemReadRequest.
4. Invalidate during REFILL beat 1 of 0x40:
   - Refill completes and Busy falls after beat 3.
   - The next fetch of 0x40 misses again.
5. Assert Reset=0 asynchronously mid-REFILL:
   - Ready, Busy, MemReadRequest and the counters read 0 before the next edge.
   - Leftover beats are ignored; a fresh fetch of the same address misses.
6. Beats with 2-cycle gaps of MemDataReady=0:
   - Busy stays 1 across the gaps and drops after the fourth beat.
   - The critical word is forwarded exactly once.
